aipp_telemetry_tx: RTL and testbench
====================================

Name: aipp_telemetry_tx

Overview:
- Transmit end of the AIPP voltage-health telemetry link.
- Sits on the power-delivery side. Accepts raw ADC rail-voltage samples and averages them over a fixed power-of-two window.
- Quantizes each average to the 4-bit v_health code and emits it as a one-cycle telemetry_vld pulse.
- Emission rules: periodic heartbeat at a programmable interval, plus an immediate fast-path emission when health first falls to or below a critical level.

Parameters:
- ADC_W, 12, ADC sample width in bits.
- AVG_LOG2, 2, log2 of the averaging window (default window is 4 samples).
- INTERVAL_W, 16, width of the heartbeat interval counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  block enable.
- adc_sample  in  ADC_W  raw rail-voltage code.
- adc_vld  in  1  sample valid.
- adc_rdy  out  1  block can accept a sample.
- cfg_v_floor  in  ADC_W  ADC code that maps to health 0.
- cfg_span_shift  in  4  right-shift applied to (avg - floor).
- cfg_interval  in  INTERVAL_W  heartbeat period in cycles; 0 means emit on every completed average.
- cfg_crit_level  in  4  fast-path threshold.
- v_health  out  4  quantized health code, held between pulses.
- telemetry_vld  out  1  one-cycle emission strobe.
- drop_cnt  out  8  saturating count of samples offered while adc_rdy=0.

Behaviour:
- Reset values: v_health=4'd15, telemetry_vld=0, adc_rdy=0, drop_cnt=0, state=IDLE. Accumulator, sample count, interval counter and pending flag are all cleared.
- States:
  - IDLE: adc_rdy=0. Moves to ACCUM on the cycle after enable=1. The interval counter starts at 0.
  - ACCUM: adc_rdy=1. Each handshake (adc_vld && adc_rdy) adds adc_sample to an accumulator of ADC_W+AVG_LOG2 bits, which cannot overflow. The handshake that completes the 2^AVG_LOG2-th sample moves the block to QUANT.
  - QUANT: exactly one cycle, adc_rdy=0.
    - avg = acc >> AVG_LOG2.
    - diff = (avg < cfg_v_floor) ? 0 : avg - cfg_v_floor.
    - h = min(diff >> cfg_span_shift, 15).
    - h is registered as pending_h, pending is set, the accumulator and count are cleared, and the block returns to ACCUM.
- Emission is evaluated every cycle the block is not in IDLE; at most one pulse per cycle.
  - Fast path: pending && pending_h <= cfg_crit_level && last emitted v_health > cfg_crit_level. Emits pending_h.
  - Heartbeat: cfg_interval != 0 and the interval counter equals cfg_interval-1. Emits pending_h if pending is set, otherwise re-emits the current v_health.
  - cfg_interval == 0: every pending value is emitted on the cycle after QUANT.
  - On any emission: v_health is updated on the same edge that raises telemetry_vld, pending is cleared, and the interval counter resets to 0.
  - Fast path and heartbeat in the same cycle: a single pulse carrying pending_h, and the counter restarts.
- Latency: the window-completing sample is accepted at edge N. QUANT occupies cycle N+1. The earliest telemetry_vld is high in cycle N+2.
- Interval counter: increments each non-IDLE cycle and resets on emission. If cfg_interval is lowered below the current count, the comparison still uses equality, so the counter wraps naturally at 2^INTERVAL_W.
- Back-pressure: adc_vld=1 while adc_rdy=0 (QUANT or IDLE with enable=1) increments drop_cnt, which saturates at 255. drop_cnt is cleared only by rst.
- enable deassert, mid-window or in QUANT: next state is IDLE; the accumulator, count and pending are cleared and no pulse is emitted. v_health and drop_cnt are held.
- rst mid-operation: all state returns to reset values immediately. telemetry_vld drops asynchronously.
- Config inputs are sampled live. Software changes them only while enable=0.

Decomposition:
- Shared package aipp_pkg holds:
  - HEALTH_W=4, HEALTH_MAX=4'd15.
  - tx state enum {IDLE, ACCUM, QUANT}.
  - the reset health constant.
  - the receiver's thresholds (8/12/2/4), so benches cross-check the link.
- One sub-module, aipp_health_quant: combinational floor-subtract, shift and saturate; instantiated in QUANT and unit-testable alone.

Test Plan:
- Reset, then enable=1, interval=0, floor=0, shift=8, four samples of 12'hC00 -> a single pulse with v_health=12, in cycle N+2 after the fourth handshake.
- Samples 12'h100 ×4, floor=12'h200 -> avg below floor saturates low, v_health=0. Samples 12'hFFF ×4 with floor=0, shift=4 -> v_health saturates at 15.
- interval=100, crit=2, previous health 12, new average giving h=1 -> fast-path pulse at N+2 without waiting for the heartbeat; counter restarts, so the next heartbeat is 100 cycles later and re-sends 1.
- interval=10, no samples supplied -> a pulse every 10 cycles re-sending v_health=15.
- adc_vld held high continuously -> exactly one drop per window (the QUANT cycle), so drop_cnt=1 after window 1. After 300 windows, drop_cnt=255.
- enable dropped after 2 of 4 samples, then re-enabled with 4 new samples of 12'h800 (shift=7, floor=0) -> no stale pulse; the result is v_health=15 from 12'h800>>7=16, saturated.

Source files
------------

// File: rtl/aipp_pkg.sv
// Shared constants and types for the AIPP voltage-health telemetry link.
// The receiver thresholds live here so both ends of the link agree on them.
package aipp_pkg;

    localparam int                  HEALTH_W   = 4;
    localparam logic [HEALTH_W-1:0] HEALTH_MAX = 4'd15;
    localparam logic [HEALTH_W-1:0] HEALTH_RST = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        QUANT = 2'd2
    } tx_state_e;

    // Receiver-side decision levels on the v_health code.
    localparam logic [HEALTH_W-1:0] RX_THR_WARN = 4'd8;
    localparam logic [HEALTH_W-1:0] RX_THR_OK   = 4'd12;
    localparam logic [HEALTH_W-1:0] RX_THR_CRIT = 4'd2;
    localparam logic [HEALTH_W-1:0] RX_HYST     = 4'd4;

endpackage

// File: rtl/aipp_health_quant.sv
// Maps an averaged rail-voltage code onto the 4-bit health scale:
// floor-subtract (clamped at zero), right-shift, saturate at HEALTH_MAX.
module aipp_health_quant
    import aipp_pkg::*;
#(
    parameter int ADC_W = 12
) (
    input  logic [ADC_W-1:0]    avg_i,
    input  logic [ADC_W-1:0]    floor_i,
    input  logic [3:0]          shift_i,
    output logic [HEALTH_W-1:0] h_o
);

    function automatic logic [HEALTH_W-1:0] sat_health(input logic [ADC_W-1:0] v);
        if (v > ADC_W'(HEALTH_MAX)) begin
            return HEALTH_MAX;
        end
        return v[HEALTH_W-1:0];
    endfunction

    logic [ADC_W-1:0] diff;
    logic [ADC_W-1:0] scaled;

    always_comb begin
        diff   = (avg_i < floor_i) ? '0 : (avg_i - floor_i);
        scaled = diff >> shift_i;
        h_o    = sat_health(scaled);
    end

endmodule

// File: rtl/aipp_telemetry_tx.sv
// AIPP telemetry transmitter: averages ADC rail samples over a power-of-two
// window, quantizes to v_health and emits it on heartbeat or critical drop.
module aipp_telemetry_tx
    import aipp_pkg::*;
#(
    parameter int ADC_W      = 12,
    parameter int AVG_LOG2   = 2,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ADC_W-1:0]      adc_sample,
    input  logic                  adc_vld,
    output logic                  adc_rdy,
    input  logic [ADC_W-1:0]      cfg_v_floor,
    input  logic [3:0]            cfg_span_shift,
    input  logic [INTERVAL_W-1:0] cfg_interval,
    input  logic [3:0]            cfg_crit_level,
    output logic [HEALTH_W-1:0]   v_health,
    output logic                  telemetry_vld,
    output logic [7:0]            drop_cnt
);

    localparam int                ACC_W       = ADC_W + AVG_LOG2;
    localparam int                SCNT_W      = AVG_LOG2 + 1;
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);

    tx_state_e             state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [INTERVAL_W-1:0] icnt_q, icnt_d;
    logic                  pend_q, pend_d;
    logic [HEALTH_W-1:0]   pend_h_q, pend_h_d;
    logic [HEALTH_W-1:0]   vh_q, vh_d;
    logic                  vld_q, vld_d;
    logic [7:0]            drop_q, drop_d;

    logic [ADC_W-1:0]      avg;
    logic [HEALTH_W-1:0]   quant_h;
    logic                  in_quant;
    logic                  hs;
    logic                  eff_pend;
    logic [HEALTH_W-1:0]   eff_h;
    logic                  fast_hit;
    logic                  hb_hit;
    logic                  zero_hit;
    logic                  emit;

    assign avg = acc_q[ACC_W-1:AVG_LOG2];

    aipp_health_quant #(
        .ADC_W (ADC_W)
    ) u_quant (
        .avg_i   (avg),
        .floor_i (cfg_v_floor),
        .shift_i (cfg_span_shift),
        .h_o     (quant_h)
    );

    assign adc_rdy       = (state_q == ACCUM);
    assign v_health      = vh_q;
    assign telemetry_vld = vld_q;
    assign drop_cnt      = drop_q;

    // The QUANT result is treated as already pending so it can be emitted on
    // the edge that leaves QUANT, giving the pulse one cycle after QUANT.
    always_comb begin
        in_quant = (state_q == QUANT);
        hs       = adc_vld && adc_rdy;
        eff_pend = pend_q || in_quant;
        eff_h    = in_quant ? quant_h : pend_h_q;
        fast_hit = eff_pend && (eff_h <= cfg_crit_level) && (vh_q > cfg_crit_level);
        hb_hit   = (cfg_interval != '0) && (icnt_q == (cfg_interval - INTERVAL_W'(1)));
        zero_hit = (cfg_interval == '0) && eff_pend;
        emit     = enable && (state_q != IDLE) && (fast_hit || hb_hit || zero_hit);
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        scnt_d   = scnt_q;
        icnt_d   = icnt_q;
        pend_d   = pend_q;
        pend_h_d = pend_h_q;
        vh_d     = vh_q;
        vld_d    = 1'b0;
        drop_d   = drop_q;

        if (adc_vld && !adc_rdy && (in_quant || ((state_q == IDLE) && enable))
            && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                icnt_d = '0;
                if (enable) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                icnt_d = icnt_q + INTERVAL_W'(1);
                if (hs) begin
                    acc_d  = acc_q + ACC_W'(adc_sample);
                    scnt_d = scnt_q + SCNT_W'(1);
                    if (scnt_q == LAST_SAMPLE) begin
                        state_d = QUANT;
                    end
                end
            end
            QUANT: begin
                icnt_d   = icnt_q + INTERVAL_W'(1);
                pend_h_d = quant_h;
                pend_d   = 1'b1;
                acc_d    = '0;
                scnt_d   = '0;
                state_d  = ACCUM;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit) begin
            vld_d  = 1'b1;
            vh_d   = eff_pend ? eff_h : vh_q;
            pend_d = 1'b0;
            icnt_d = '0;
        end

        // Disabling abandons the window in flight; health and drops are kept.
        if (!enable) begin
            state_d = IDLE;
            acc_d   = '0;
            scnt_d  = '0;
            pend_d  = 1'b0;
            icnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            scnt_q   <= '0;
            icnt_q   <= '0;
            pend_q   <= 1'b0;
            pend_h_q <= '0;
            vh_q     <= HEALTH_RST;
            vld_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            icnt_q   <= icnt_d;
            pend_q   <= pend_d;
            pend_h_q <= pend_h_d;
            vh_q     <= vh_d;
            vld_q    <= vld_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_aipp_telemetry_tx.sv
// Self-checking bench for aipp_telemetry_tx: table of quantizer windows plus
// hand sequences for heartbeat, fast path, back-pressure, enable and reset.
module tb_aipp_telemetry_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [11:0] adc_sample;
    logic        adc_vld;
    logic        adc_rdy;
    logic [11:0] cfg_v_floor;
    logic [3:0]  cfg_span_shift;
    logic [15:0] cfg_interval;
    logic [3:0]  cfg_crit_level;
    logic [3:0]  v_health;
    logic        telemetry_vld;
    logic [7:0]  drop_cnt;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] h;
        int         due;
    } exp_t;

    typedef struct {
        logic [11:0] s0, s1, s2, s3;
        logic [11:0] floor;
        logic [3:0]  shift;
        logic [3:0]  exp_h;
    } vec_t;

    exp_t q[$];
    vec_t vecs[9];

    aipp_telemetry_tx #(
        .ADC_W      (12),
        .AVG_LOG2   (2),
        .INTERVAL_W (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .adc_sample     (adc_sample),
        .adc_vld        (adc_vld),
        .adc_rdy        (adc_rdy),
        .cfg_v_floor    (cfg_v_floor),
        .cfg_span_shift (cfg_span_shift),
        .cfg_interval   (cfg_interval),
        .cfg_crit_level (cfg_crit_level),
        .v_health       (v_health),
        .telemetry_vld  (telemetry_vld),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected entry in value and cycle.
    always @(negedge clk) begin
        if (!rst && telemetry_vld) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: v_health=%0d at cycle %0d, no pulse expected", v_health, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_value", int'(v_health), int'(e.h));
                chk("pulse_cycle", cyc, e.due);
            end
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        enable  = 1'b0;
        adc_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic wait_rdy();
        int t = 0;
        @(negedge clk);
        while (!adc_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!adc_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdy_timeout: adc_rdy=0 after %0d cycles, expected 1", t);
        end
    endtask

    // Entered and left just after a rising edge; returns the accepting edge count.
    task automatic send(input logic [11:0] s, output int edge_n);
        adc_sample = s;
        adc_vld    = 1'b1;
        wait_rdy();
        @(posedge clk);
        #1;
        edge_n  = cyc;
        adc_vld = 1'b0;
    endtask

    task automatic window(input logic [11:0] a, b, c, d, input logic [3:0] exp_h, output int edge_n);
        int e;
        send(a, e);
        send(b, e);
        send(c, e);
        send(d, e);
        q.push_back('{h: exp_h, due: e + 1});
        edge_n = e;
    endtask

    task automatic set_cfg(input logic [11:0] fl, input logic [3:0] sh,
                           input logic [15:0] iv, input logic [3:0] cr);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        cfg_v_floor    = fl;
        cfg_span_shift = sh;
        cfg_interval   = iv;
        cfg_crit_level = cr;
        enable         = 1'b1;
        wait_rdy();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int k0;
        int st;
        int t;

        vecs[0] = '{12'hC00, 12'hC00, 12'hC00, 12'hC00, 12'h000, 4'd8,  4'd12};
        vecs[1] = '{12'h100, 12'h100, 12'h100, 12'h100, 12'h200, 4'd8,  4'd0};
        vecs[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 4'd4,  4'd15};
        vecs[3] = '{12'h400, 12'h500, 12'h600, 12'h700, 12'h300, 4'd6,  4'd10};
        vecs[4] = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'h5E0, 4'd0,  4'd15};
        vecs[5] = '{12'h200, 12'h200, 12'h200, 12'h200, 12'h200, 4'd0,  4'd0};
        vecs[6] = '{12'h210, 12'h210, 12'h210, 12'h210, 12'h200, 4'd0,  4'd15};
        vecs[7] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 4'd15, 4'd0};
        vecs[8] = '{12'h003, 12'h003, 12'h003, 12'h002, 12'h000, 4'd0,  4'd2};

        rst            = 1'b1;
        enable         = 1'b0;
        adc_vld        = 1'b0;
        adc_sample     = '0;
        cfg_v_floor    = '0;
        cfg_span_shift = 4'd8;
        cfg_interval   = '0;
        cfg_crit_level = '0;
        do_reset();

        @(negedge clk);
        chk("rst_v_health", int'(v_health), 15);
        chk("rst_vld", int'(telemetry_vld), 0);
        chk("rst_rdy", int'(adc_rdy), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i].floor, vecs[i].shift, 16'd0, 4'd0);
            window(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].exp_h, e);
            drain("table_drain");
            @(negedge clk);
            chk("table_hold", int'(v_health), int'(vecs[i].exp_h));
        end

        // Fast path: health 12 -> 1 with crit 2 fires immediately, heartbeat 100 later.
        do_reset();
        set_cfg(12'h000, 4'd8, 16'd0, 4'd2);
        window(12'hC00, 12'hC00, 12'hC00, 12'hC00, 4'd12, e);
        drain("fast_prep_drain");
        set_cfg(12'h000, 4'd8, 16'd100, 4'd2);
        window(12'h180, 12'h180, 12'h180, 12'h180, 4'd1, e);
        q.push_back('{h: 4'd1, due: e + 1 + 100});
        drain("fast_drain");
        @(posedge clk);
        #1;
        enable = 1'b0;

        // Heartbeat only: interval 10, no samples, re-sends reset health.
        do_reset();
        cfg_v_floor    = '0;
        cfg_span_shift = 4'd8;
        cfg_interval   = 16'd10;
        cfg_crit_level = 4'd0;
        @(posedge clk);
        #1;
        k0     = cyc;
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) q.push_back('{h: 4'd15, due: k0 + 1 + 10 * i});
        drain("hb_drain");

        // Async reset while a pulse is high must drop it at once.
        t = 0;
        while (cyc != k0 + 41 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("hb4_pulse_high", int'(telemetry_vld), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_vld", int'(telemetry_vld), 0);
        chk("async_rst_rdy", int'(adc_rdy), 0);
        do_reset();

        // Back-pressure: adc_vld held high drops exactly the QUANT cycle each window.
        cfg_v_floor    = '0;
        cfg_span_shift = 4'd8;
        cfg_interval   = '0;
        cfg_crit_level = 4'd0;
        adc_sample     = 12'hC00;
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_rdy();
        @(posedge clk);
        #1;
        st      = cyc;
        adc_vld = 1'b1;
        for (int k = 0; k < 300; k++) q.push_back('{h: 4'd12, due: st + 5 + 5 * k});
        while (cyc < st + 4) @(negedge clk);
        chk("bp_drop_before", int'(drop_cnt), 0);
        chk("bp_rdy_quant", int'(adc_rdy), 0);
        @(negedge clk);
        chk("bp_drop_win1", int'(drop_cnt), 1);
        while (cyc < st + 1502) @(negedge clk);
        chk("bp_drop_sat", int'(drop_cnt), 255);
        @(posedge clk);
        #1;
        adc_vld = 1'b0;
        drain("bp_drain");
        repeat (10) @(negedge clk);
        chk("bp_drop_hold", int'(drop_cnt), 255);

        // Enable dropped mid-window: partial window discarded, no stale pulse.
        do_reset();
        set_cfg(12'h000, 4'd7, 16'd0, 4'd0);
        send(12'h100, e);
        send(12'h100, e);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("dis_rdy", int'(adc_rdy), 0);
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b1;
        window(12'h800, 12'h800, 12'h800, 12'h800, 4'd15, e);
        drain("dis_drain");
        repeat (10) @(negedge clk);
        chk("dis_hold", int'(v_health), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
